// File: rtl/sample_feeder.sv
// Sample feeder: replays a block of IF samples from a synchronous RAM onto clk_sample/sample_valid/data, framed by feed_reset/feed_complete pulses.
// Latency: all outputs registered; feed_reset from the cycle after start, first sample PULSE_CYCLES+2 cycles later, one sample per 2*HALF_PERIOD cycles.
// Backpressure: none, the stream is free-running; abort drops to IDLE next cycle. Optional macro FEEDER_REPEAT_EN replays the block repeat_count extra times.
module sample_feeder #(
  parameter int INPUT_WIDTH  = 3,
  parameter int ADDR_WIDTH   = 14,
  parameter int HALF_PERIOD  = 4,
  parameter int PULSE_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   global_reset_n_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [ADDR_WIDTH:0]    num_samples_i,
  input  logic [7:0]             repeat_count_i,
  output logic                   mem_rd_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic [INPUT_WIDTH-1:0] mem_data_i,
  output logic                   clk_sample_o,
  output logic                   sample_valid_o,
  output logic                   feed_reset_o,
  output logic                   feed_complete_o,
  output logic [INPUT_WIDTH-1:0] data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_PRIME, S_STREAM, S_COMPLETE} state_t;

  localparam logic [7:0]            PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0]            HALF_LAST  = 8'(HALF_PERIOD - 1);
  localparam logic [ADDR_WIDTH:0]   SAMP_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [7:0]             phase_q, phase_d;
  logic [ADDR_WIDTH:0]    samp_q, samp_d;
  logic [ADDR_WIDTH:0]    nsamp_q, nsamp_d;
  logic [INPUT_WIDTH-1:0] prefetch_q, prefetch_d;
  logic                   rd_pend_q;

  logic                   mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   clk_sample_q, clk_sample_d;
  logic                   sample_valid_q, sample_valid_d;
  logic                   feed_reset_q, feed_reset_d;
  logic                   feed_complete_q, feed_complete_d;
  logic [INPUT_WIDTH-1:0] data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  // Helpers shared between the states that launch a new sample period.
  logic                   new_sample;
  logic [ADDR_WIDTH:0]    new_samp;
  logic                   more_passes;
  logic                   go_complete;

`ifdef FEEDER_REPEAT_EN
  logic [7:0]             rep_q, rep_d;
  logic [7:0]             pass_q, pass_d;
  logic [7:0]             new_pass;
`else
  logic                   unused_repeat;
  assign unused_repeat = ^repeat_count_i;
`endif

  // Next-state and registered-output computation for the feed sequencer.
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    samp_d          = samp_q;
    nsamp_d         = nsamp_q;
    prefetch_d      = rd_pend_q ? mem_data_i : prefetch_q;
    mem_rd_d        = 1'b0;
    mem_addr_d      = mem_addr_q;
    clk_sample_d    = 1'b0;
    sample_valid_d  = 1'b0;
    feed_reset_d    = 1'b0;
    feed_complete_d = 1'b0;
    data_d          = '0;
    busy_d          = 1'b0;
    done_d          = 1'b0;
    new_sample      = 1'b0;
    new_samp        = '0;
    more_passes     = 1'b0;
    go_complete     = 1'b0;
`ifdef FEEDER_REPEAT_EN
    rep_d           = rep_q;
    pass_d          = pass_q;
    new_pass        = pass_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d      = S_RESET;
          phase_d      = '0;
          samp_d       = '0;
          nsamp_d      = num_samples_i;
          mem_addr_d   = '0;
          feed_reset_d = 1'b1;
          busy_d       = 1'b1;
`ifdef FEEDER_REPEAT_EN
          rep_d        = repeat_count_i;
          pass_d       = '0;
`endif
        end
      end

      S_RESET: begin
        busy_d = 1'b1;
        if (phase_q == PULSE_LAST) begin
          phase_d = '0;
          if (nsamp_q == '0) begin
            state_d         = S_COMPLETE;
            feed_complete_d = 1'b1;
          end else begin
            state_d    = S_PRIME;
            mem_rd_d   = 1'b1;
            mem_addr_d = '0;
          end
        end else begin
          phase_d      = phase_q + 8'd1;
          feed_reset_d = 1'b1;
        end
      end

      S_PRIME: begin
        busy_d = 1'b1;
        if (phase_q == '0) begin
          phase_d = 8'd1;
        end else begin
          // Read data for address 0 is arriving now; prefetch_d forwards it.
          state_d    = S_STREAM;
          new_sample = 1'b1;
          new_samp   = '0;
        end
      end

      S_STREAM: begin
        busy_d         = 1'b1;
        sample_valid_d = 1'b1;
        data_d         = data_q;
        clk_sample_d   = clk_sample_q;
        if (phase_q != HALF_LAST) begin
          phase_d = phase_q + 8'd1;
        end else if (!clk_sample_q) begin
          phase_d      = '0;
          clk_sample_d = 1'b1;
        end else if (samp_q == nsamp_q - SAMP_ONE) begin
`ifdef FEEDER_REPEAT_EN
          if (pass_q < rep_q) begin
            new_pass   = pass_q + 8'd1;
            pass_d     = new_pass;
            new_sample = 1'b1;
            new_samp   = '0;
          end else begin
            go_complete = 1'b1;
          end
`else
          go_complete = 1'b1;
`endif
        end else begin
          new_sample = 1'b1;
          new_samp   = samp_q + SAMP_ONE;
        end
      end

      S_COMPLETE: begin
        if (phase_q == PULSE_LAST) begin
          state_d = S_IDLE;
          phase_d = '0;
          done_d  = 1'b1;
        end else begin
          phase_d         = phase_q + 8'd1;
          feed_complete_d = 1'b1;
          busy_d          = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

`ifdef FEEDER_REPEAT_EN
    more_passes = (new_pass < rep_q);
`endif

    // Start of a sample's low phase: present the prefetched value and fetch the next one.
    if (new_sample) begin
      phase_d        = '0;
      samp_d         = new_samp;
      clk_sample_d   = 1'b0;
      sample_valid_d = 1'b1;
      data_d         = prefetch_d;
      if (new_samp + SAMP_ONE < nsamp_q) begin
        mem_rd_d   = 1'b1;
        mem_addr_d = mem_addr_q + ADDR_ONE;
      end else if (more_passes) begin
        // Next pass begins from address 0 without a gap in clk_sample.
        mem_rd_d   = 1'b1;
        mem_addr_d = '0;
      end
    end

    if (go_complete) begin
      state_d         = S_COMPLETE;
      phase_d         = '0;
      clk_sample_d    = 1'b0;
      sample_valid_d  = 1'b0;
      data_d          = '0;
      mem_addr_d      = '0;
      feed_complete_d = 1'b1;
    end

    // Abort overrides everything outside IDLE: silent return, no completion pulse.
    if (abort_i && (state_q != S_IDLE)) begin
      state_d         = S_IDLE;
      phase_d         = '0;
      mem_rd_d        = 1'b0;
      mem_addr_d      = '0;
      clk_sample_d    = 1'b0;
      sample_valid_d  = 1'b0;
      feed_reset_d    = 1'b0;
      feed_complete_d = 1'b0;
      data_d          = '0;
      busy_d          = 1'b0;
      done_d          = 1'b0;
    end
  end

  // State, counters and registered outputs; reset forces every output low at once.
  always_ff @(posedge clk_i or negedge global_reset_n_i) begin
    if (!global_reset_n_i) begin
      state_q         <= S_IDLE;
      phase_q         <= '0;
      samp_q          <= '0;
      nsamp_q         <= '0;
      prefetch_q      <= '0;
      rd_pend_q       <= 1'b0;
      mem_rd_q        <= 1'b0;
      mem_addr_q      <= '0;
      clk_sample_q    <= 1'b0;
      sample_valid_q  <= 1'b0;
      feed_reset_q    <= 1'b0;
      feed_complete_q <= 1'b0;
      data_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef FEEDER_REPEAT_EN
      rep_q           <= '0;
      pass_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      samp_q          <= samp_d;
      nsamp_q         <= nsamp_d;
      prefetch_q      <= prefetch_d;
      rd_pend_q       <= mem_rd_q;
      mem_rd_q        <= mem_rd_d;
      mem_addr_q      <= mem_addr_d;
      clk_sample_q    <= clk_sample_d;
      sample_valid_q  <= sample_valid_d;
      feed_reset_q    <= feed_reset_d;
      feed_complete_q <= feed_complete_d;
      data_q          <= data_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
`ifdef FEEDER_REPEAT_EN
      rep_q           <= rep_d;
      pass_q          <= pass_d;
`endif
    end
  end

  assign mem_rd_o        = mem_rd_q;
  assign mem_addr_o      = mem_addr_q;
  assign clk_sample_o    = clk_sample_q;
  assign sample_valid_o  = sample_valid_q;
  assign feed_reset_o    = feed_reset_q;
  assign feed_complete_o = feed_complete_q;
  assign data_o          = data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Directed bench for sample_feeder: records each feed cycle by cycle and checks pulse timing, sample edges and data.
// Cycle k is the cycle after clock edge k-1; start is sampled at edge 0.
// RAM is modelled as a synchronous read with one cycle of latency.
module tb_sample_feeder;
  localparam int IW = 3;
  localparam int AW = 14;
  localparam int NC = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW:0]   num_samples;
  logic [7:0]    repeat_count;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_data;
  logic          clk_sample;
  logic          sample_valid;
  logic          feed_reset;
  logic          feed_complete;
  logic [IW-1:0] data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  sample_feeder #(.INPUT_WIDTH(IW), .ADDR_WIDTH(AW), .HALF_PERIOD(4), .PULSE_CYCLES(4)) dut (
    .clk_i(clk), .global_reset_n_i(rst_n), .start_i(start), .abort_i(abort),
    .num_samples_i(num_samples), .repeat_count_i(repeat_count),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .clk_sample_o(clk_sample), .sample_valid_o(sample_valid),
    .feed_reset_o(feed_reset), .feed_complete_o(feed_complete),
    .data_o(data), .busy_o(busy), .done_o(done)
  );

  logic [IW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-cycle trace of the last feed.
  int cs_a[NC], sv_a[NC], dat_a[NC], fr_a[NC], fc_a[NC], busy_a[NC], done_a[NC], rd_a[NC], addr_a[NC];
  // Summary derived from the trace.
  int n_rise, rise_cyc[8], rise_dat[8];
  int fr_first, fr_cnt, fc_first, fc_cnt, done_first, done_cnt, busy_first, busy_last, rd_cnt;

  function automatic int all_outs();
    return int'({mem_rd, clk_sample, sample_valid, feed_reset, feed_complete, busy, done, data, mem_addr});
  endfunction

  task automatic record(input int k);
    cs_a[k] = int'(clk_sample);  sv_a[k] = int'(sample_valid); dat_a[k] = int'(data);
    fr_a[k] = int'(feed_reset);  fc_a[k] = int'(feed_complete); busy_a[k] = int'(busy);
    done_a[k] = int'(done);      rd_a[k] = int'(mem_rd);        addr_a[k] = int'(mem_addr);
  endtask

  // Start a feed at cycle 0 and trace NC cycles; optional abort / second start at given cycles.
  task automatic run(input int n, input int rep, input int abort_at, input int start2_at);
    num_samples  = (AW+1)'(n);
    repeat_count = 8'(rep);
    @(negedge clk);
    start = 1'b1;
    record(0);
    for (int k = 1; k < NC; k++) begin
      @(negedge clk);
      start = (k == start2_at);
      abort = (k == abort_at);
      record(k);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic analyse();
    n_rise = 0; fr_first = -1; fr_cnt = 0; fc_first = -1; fc_cnt = 0;
    done_first = -1; done_cnt = 0; busy_first = -1; busy_last = -1; rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin rise_cyc[i] = -1; rise_dat[i] = -1; end
    for (int k = 0; k < NC; k++) begin
      if (k > 0 && cs_a[k] == 1 && cs_a[k-1] == 0) begin
        if (n_rise < 8) begin rise_cyc[n_rise] = k; rise_dat[n_rise] = dat_a[k]; end
        n_rise++;
      end
      if (fr_a[k] == 1) begin if (fr_first < 0) fr_first = k; fr_cnt++; end
      if (fc_a[k] == 1) begin if (fc_first < 0) fc_first = k; fc_cnt++; end
      if (done_a[k] == 1) begin if (done_first < 0) done_first = k; done_cnt++; end
      if (busy_a[k] == 1) begin if (busy_first < 0) busy_first = k; busy_last = k; end
      if (rd_a[k] == 1) rd_cnt++;
    end
  endtask

  // Expected waveform of the basic 3-sample feed with RAM = {5,2,7}.
  task automatic check_s1(input string p);
    int exp_rise[3] = '{11, 19, 27};
    int exp_dat[3]  = '{5, 2, 7};
    analyse();
    check({p, ".fr_first"}, fr_first, 1);
    check({p, ".fr_cnt"}, fr_cnt, 4);
    check({p, ".prime_rd"}, rd_a[5], 1);
    check({p, ".prime_addr"}, addr_a[5], 0);
    check({p, ".sv_c6"}, sv_a[6], 0);
    check({p, ".sv_c7"}, sv_a[7], 1);
    check({p, ".dat_c7"}, dat_a[7], 5);
    check({p, ".dat_c15"}, dat_a[15], 2);
    check({p, ".dat_c23"}, dat_a[23], 7);
    check({p, ".n_rise"}, n_rise, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.rise%0d_cyc", p, i), rise_cyc[i], exp_rise[i]);
      check($sformatf("%s.rise%0d_dat", p, i), rise_dat[i], exp_dat[i]);
    end
    check({p, ".rd_cnt"}, rd_cnt, 3);
    check({p, ".sv_c31"}, sv_a[31], 0);
    check({p, ".fc_first"}, fc_first, 31);
    check({p, ".fc_cnt"}, fc_cnt, 4);
    check({p, ".done_cyc"}, done_first, 35);
    check({p, ".done_cnt"}, done_cnt, 1);
    check({p, ".busy_first"}, busy_first, 1);
    check({p, ".busy_last"}, busy_last, 34);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    num_samples = '0; repeat_count = '0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    ram[0] = 3'd5; ram[1] = 3'd2; ram[2] = 3'd7;

    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic feed
    run(3, 0, -1, -1);
    check_s1("s1");

    // 2: empty block
    run(0, 0, -1, -1);
    analyse();
    check("s2.fr_first", fr_first, 1);
    check("s2.fr_cnt", fr_cnt, 4);
    check("s2.fc_first", fc_first, 5);
    check("s2.fc_cnt", fc_cnt, 4);
    check("s2.n_rise", n_rise, 0);
    check("s2.rd_cnt", rd_cnt, 0);
    check("s2.done_cyc", done_first, 9);

    // 3: abort at cycle 16
    run(3, 0, 16, -1);
    analyse();
    check("s3.cs_c17", cs_a[17], 0);
    check("s3.sv_c17", sv_a[17], 0);
    check("s3.busy_c17", busy_a[17], 0);
    check("s3.busy_last", busy_last, 16);
    check("s3.n_rise", n_rise, 1);
    check("s3.rise0_cyc", rise_cyc[0], 11);
    check("s3.fc_cnt", fc_cnt, 0);
    check("s3.done_cnt", done_cnt, 0);

    // abort together with start in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("idle_abort.busy", int'(busy), 0);
    check("idle_abort.fr", int'(feed_reset), 0);

    // 4: reset in the middle of the stream, then a clean feed
    num_samples = (AW+1)'(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("s4.cs_before_rst", int'(clk_sample), 1);
    rst_n = 1'b0;
    #1;
    check("s4.async_outs", all_outs(), 0);
    repeat (2) @(negedge clk);
    check("s4.held_outs", all_outs(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(3, 0, -1, -1);
    check_s1("s4");

    // 5: second start while busy is ignored
    run(3, 0, -1, 10);
    check_s1("s5");

    // 6: repeated passes over RAM = {1,3}
    ram[0] = 3'd1; ram[1] = 3'd3;
    run(2, 2, -1, -1);
    analyse();
    begin
`ifdef FEEDER_REPEAT_EN
      int exp_n = 6;
      int exp_fc = 55;
      int exp_done = 59;
`else
      int exp_n = 2;
      int exp_fc = 23;
      int exp_done = 27;
`endif
      check("s6.n_rise", n_rise, exp_n);
      for (int i = 0; i < exp_n; i++) begin
        check($sformatf("s6.rise%0d_cyc", i), rise_cyc[i], 11 + 8 * i);
        check($sformatf("s6.rise%0d_dat", i), rise_dat[i], (i % 2 == 0) ? 1 : 3);
      end
      check("s6.fr_cnt", fr_cnt, 4);
      check("s6.fc_first", fc_first, exp_fc);
      check("s6.fc_cnt", fc_cnt, 4);
      check("s6.done_cyc", done_first, exp_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_feeder.md
Name: sample_feeder

Overview:
- Transmit end of the channel sample-input interface.
- Replays a stored block of IF samples from a synchronous sample RAM onto clk_sample/sample_valid/data.
- Brackets the stream with feed_reset and feed_complete pulses, sized so the receiver's 2-flop synchronizers and rising-edge strobe capture every sample.
- Sits between the sample buffer and the channel top in lab and FPGA test builds.

Parameters:
- INPUT_WIDTH, 3, sample width, equal to the channel `INPUT_WIDTH.
- ADDR_WIDTH, 14, sample RAM address width; max block is 2^ADDR_WIDTH samples.
- HALF_PERIOD, 4, clk cycles per clk_sample phase; legal range 3..255.
- PULSE_CYCLES, 4, clk cycles that feed_reset and feed_complete are held high; minimum 3.

Ports:
- clk  in  1  system clock.
- global_reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a feed; ignored while busy.
- abort  in  1  stop the feed immediately.
- num_samples  in  ADDR_WIDTH+1  sample count, latched on start.
- repeat_count  in  8  extra passes, latched on start; used only with FEEDER_REPEAT_EN.
- mem_rd  out  1  RAM read enable.
- mem_addr  out  ADDR_WIDTH  RAM read address.
- mem_data  in  INPUT_WIDTH  RAM read data; valid 1 cycle after mem_rd.
- clk_sample  out  1  sample clock to the channel.
- sample_valid  out  1  data qualifier.
- feed_reset  out  1  start-of-feed pulse.
- feed_complete  out  1  end-of-feed pulse.
- data  out  INPUT_WIDTH  sample value.
- busy  out  1  feed in progress.
- done  out  1  one-cycle pulse when a feed finishes normally.

Behaviour:
- Reset value of every output is 0. FSM resets to IDLE. All outputs are registered.
- IDLE:
  - start=1 at edge N: latch num_samples and repeat_count, clear address, go to RESET; busy=1 from cycle N+1.
  - start while busy is ignored.
- RESET: feed_reset=1 for exactly PULSE_CYCLES cycles, then go to PRIME.
- PRIME (2 cycles):
  - Cycle 1: mem_rd=1, mem_addr=0.
  - Cycle 2: capture mem_data into the prefetch register.
  - Then go to STREAM.
  - If num_samples==0, go from RESET directly to COMPLETE (no clk_sample edges).
- STREAM: each sample period is 2*HALF_PERIOD cycles, low phase first.
  - Low phase, first cycle: clk_sample=0, data=prefetch, sample_valid=1.
  - Low phase, same cycle: mem_rd=1 at next address; mem_data captured into prefetch on the following cycle.
  - Data is therefore stable HALF_PERIOD cycles before the clk_sample rising edge.
  - High phase: clk_sample=1; data and sample_valid are held.
  - After the high phase of the last sample, go to COMPLETE.
  - No mem_rd is issued beyond address num_samples-1.
- COMPLETE:
  - clk_sample=0, sample_valid=0, data=0.
  - feed_complete=1 for PULSE_CYCLES cycles.
  - Then go to IDLE: done=1 for one cycle, busy=0 in the same cycle.
- abort (any non-IDLE state):
  - Next cycle: FSM=IDLE and all outputs 0.
  - No feed_complete and no done.
  - abort in IDLE has no effect; abort and start together in IDLE: abort wins.
- Reset mid-feed: all outputs drop asynchronously to 0. The receiver sees no rising clk_sample edge.
- Counters:
  - Phase counter: 8 bits.
  - Sample counter: ADDR_WIDTH+1 bits, compared against latched num_samples.
  - Address wraps 2^ADDR_WIDTH-1 -> 0 only when num_samples = 2^ADDR_WIDTH and the last read has been issued (no extra read).

Optional Feature:
- Macro: FEEDER_REPEAT_EN.
- Defined:
  - After the last sample of a pass, if the passes done so far ≤ repeat_count, the address returns to 0 and streaming continues seamlessly.
  - Pass boundary: PRIME-style fetch of address 0 overlaps the final high phase; no gap in clk_sample; no feed_reset between passes.
  - Total samples = num_samples*(repeat_count+1).
  - feed_complete is issued only after the final pass.
- Not defined: repeat_count is ignored, exactly one pass.

Test Plan:
1. HALF_PERIOD=4, PULSE_CYCLES=4, RAM={5,2,7}, num_samples=3, start at cycle 0:
   - feed_reset high cycles 1-4.
   - Rising clk_sample at cycles 11, 19, 27 with data 5, 2, 7 held from cycles 7, 15, 23.
   - feed_complete high cycles 31-34; done=1 at cycle 35.
   - busy high cycles 1-34.
2. num_samples=0 -> feed_reset for 4 cycles, then feed_complete for 4 cycles. Zero clk_sample edges, zero mem_rd, done at cycle 9.
3. abort at cycle 16 of scenario 1:
   - Cycle 17: clk_sample=0, sample_valid=0, busy=0.
   - Exactly one rising clk_sample seen; no feed_complete, no done.
4. global_reset_n low mid-STREAM -> all outputs 0 immediately. A subsequent start reproduces scenario 1 timing exactly.
5. start pulsed again at cycle 10 of scenario 1 -> ignored; waveform identical to scenario 1.
6. FEEDER_REPEAT_EN, RAM={1,3}, num_samples=2, repeat_count=2:
   - Six rising edges with data 1, 3, 1, 3, 1, 3 at a constant 8-cycle period.
   - One feed_reset, one feed_complete.
   - Without the macro: two edges only.
